// File: rtl/button_event_arbiter.sv
// button_event_arbiter: rising-edge capture of debounced button levels,
// round-robin arbitration of pending events into a small command FIFO
// with sticky per-requester overflow flags.
// Optional feature: define BTN_ARB_HOLDOFF_EN to enable per-requester
// re-trigger holdoff counters (HOLDOFF cycles after each grant).
module button_event_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned HOLDOFF    = 1000
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N_REQ-1:0]                ev_in,
    output logic                            cmd_valid,
    output logic [$clog2(N_REQ)-1:0]        cmd_id,
    input  logic                            cmd_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic [N_REQ-1:0]                ovf,
    input  logic                            ovf_clr
);

    localparam int unsigned IDW = $clog2(N_REQ);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_STALL = 2'd2
    } state_t;

    // Elaboration-time parameter range check
    if (N_REQ < 2 || N_REQ > 8 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || HOLDOFF < 1 || HOLDOFF > 65535) begin : g_bad_cfg
        $error("button_event_arbiter: parameter out of range");
    end

    state_t              state_q, state_d;
    logic                armed_q;
    logic [N_REQ-1:0]    ev_q;
    logic [N_REQ-1:0]    pending_q, pending_d;
    logic [N_REQ-1:0]    ovf_q, ovf_d;
    logic [N_REQ-1:0]    hold_blk;
    logic [N_REQ-1:0]    rise_c;
    logic [N_REQ-1:0]    grant_oh;
    logic [IDW-1:0]      last_grant_q, last_grant_d;
    logic [IDW-1:0]      sel;
    logic                found;
    logic                grant_en;
    logic                pop;
    logic [IDW-1:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       remain;
    logic                valid_q, valid_d;
    logic [IDW-1:0]      cmd_id_q, cmd_id_d;

    assign cmd_valid  = valid_q;
    assign cmd_id     = cmd_id_q;
    assign fifo_count = count_q;
    assign ovf        = ovf_q;
    assign pop        = valid_q & cmd_ready;

    // First post-reset edge only loads the sampler, so levels held through reset never fire
    assign rise_c = armed_q ? (ev_in & ~ev_q & ~hold_blk) : '0;

    // Input sampler and arming flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q    <= '0;
            armed_q <= 1'b0;
        end else begin
            ev_q    <= ev_in;
            armed_q <= 1'b1;
        end
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        logic [IDW-1:0] cand;
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = IDW'((32'(last_grant_q) + k) % N_REQ);
            if (!found && pending_q[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Arbiter FSM next state plus pending/ovf/FIFO next-state datapath
    always_comb begin
        state_d      = state_q;
        grant_en     = 1'b0;
        grant_oh     = '0;
        pending_d    = pending_q;
        ovf_d        = ovf_q;
        last_grant_d = last_grant_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        remain       = count_q;
        valid_d      = valid_q;
        cmd_id_d     = cmd_id_q;

        case (state_q)
            S_IDLE:  grant_en = 1'b0;
            S_GRANT: grant_en = found;
            S_STALL: grant_en = found & pop;
            default: grant_en = 1'b0;
        endcase

        if (grant_en) begin
            grant_oh[sel] = 1'b1;
            last_grant_d  = sel;
        end

        // A new edge on a requester being granted this cycle simply re-arms it
        pending_d = (pending_q & ~grant_oh) | rise_c;
        ovf_d     = (ovf_q & ~{N_REQ{ovf_clr}}) | (rise_c & pending_q & ~grant_oh);

        wr_ptr_d = wr_ptr_q + PW'(grant_en);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(grant_en) - CW'(pop);
        remain   = count_q - CW'(pop);
        valid_d  = (count_d != '0);

        // Head register: bypass the pushed id when the FIFO would otherwise be empty
        if (count_d == '0) begin
            cmd_id_d = '0;
        end else if (remain == '0) begin
            cmd_id_d = sel;
        end else begin
            cmd_id_d = mem_q[rd_ptr_d];
        end

        if (pending_d == '0) begin
            state_d = S_IDLE;
        end else if (count_d != CW'(FIFO_DEPTH)) begin
            state_d = S_GRANT;
        end else begin
            state_d = S_STALL;
        end
    end

    // State, pending, overflow and FIFO control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pending_q    <= '0;
            ovf_q        <= '0;
            last_grant_q <= IDW'(N_REQ - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            valid_q      <= 1'b0;
            cmd_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            ovf_q        <= ovf_d;
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            valid_q      <= valid_d;
            cmd_id_q     <= cmd_id_d;
        end
    end

    // FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (grant_en) begin
            mem_q[wr_ptr_q] <= sel;
        end
    end

`ifdef BTN_ARB_HOLDOFF_EN
    logic [15:0] hold_q [N_REQ];

    // A requester is blind to new edges while its holdoff counter runs
    always_comb begin
        hold_blk = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            hold_blk[i] = (hold_q[i] != 16'd0);
        end
    end

    // Holdoff counters: reload on grant, otherwise count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                hold_q[i] <= 16'd0;
            end
        end else begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (grant_oh[i]) begin
                    hold_q[i] <= 16'(HOLDOFF);
                end else if (hold_q[i] != 16'd0) begin
                    hold_q[i] <= hold_q[i] - 16'd1;
                end
            end
        end
    end
`else
    assign hold_blk = '0;
`endif

endmodule

// File: doc/button_event_arbiter.md
BUTTON_EVENT_ARBITER -- requirements
Module: button_event_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of debounced event requesters (2..8).
REQ-002 Parameter FIFO_DEPTH, default 4: command FIFO entries, power of two (2..16).
REQ-003 Parameter HOLDOFF, default 1000: per-requester re-trigger holdoff in clk cycles (1..65535).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 ev_in  in  N_REQ  debouncer outputs, level; may stay high indefinitely.
REQ-007 cmd_valid  out  1  FIFO head holds a command.
REQ-008 cmd_id  out  clog2(N_REQ)  requester index at FIFO head.
REQ-009 cmd_ready  in  1  downstream (I2C slave register side) accepts head.
REQ-010 fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries.
REQ-011 ovf  out  N_REQ  sticky per-requester overflow flags.
REQ-012 ovf_clr  in  1  one-cycle pulse clearing all ovf bits.

Function
REQ-013 Each ev_in bit SHALL be registered once and rising-edge detected (0 in previous sample, 1 in current); levels held high SHALL NOT generate further events.
REQ-014 A detected edge SHALL set pending[i]; an edge while pending[i] is already set SHALL set ovf[i] and leave pending[i] set (event dropped).
REQ-015 Arbiter: round-robin over pending bits, search starting at last_grant+1 modulo N_REQ; last_grant resets to N_REQ-1 so requester 0 wins first.
REQ-016 At most one grant per cycle, only when FIFO not full or a pop occurs the same cycle.
REQ-017 A grant SHALL clear pending[i], push i into the FIFO and update last_grant to i, all in the same edge.
REQ-018 Edge-to-cmd_valid latency with empty FIFO and no contention: 2 cycles (sample register, then grant/push).
REQ-019 Edge for requester i arriving in the same cycle pending[i] is granted SHALL re-set pending[i] and SHALL NOT set ovf[i].
REQ-020 FIFO: pop when cmd_valid and cmd_ready; push and pop in the same cycle when full SHALL be permitted and keep fifo_count unchanged.
REQ-021 cmd_valid SHALL equal (fifo_count != 0); cmd_id SHALL be stable while cmd_valid and not cmd_ready.
REQ-022 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or underflow.
REQ-023 ovf_clr SHALL clear ovf; an overflow event in the same cycle SHALL win (bit remains set).
REQ-024 Arbiter states: IDLE (no pending), GRANT (pending and space), STALL (pending, FIFO full, no pop); STALL to GRANT on first cycle space exists.

Reset
REQ-025 While rst_n low: pending, ovf, sampled ev_in, FIFO pointers and fifo_count SHALL be 0; cmd_valid 0; cmd_id 0; last_grant N_REQ-1; holdoff counters 0.
REQ-026 Reset mid-operation SHALL discard all queued and pending events; an ev_in held high through reset release SHALL NOT produce an event (sampled register loads current level on first post-reset edge without edge detection).

Configuration
REQ-027 Macro BTN_ARB_HOLDOFF_EN defined: each grant of requester i SHALL load a 16-bit counter with HOLDOFF; edges on i while counter nonzero SHALL be ignored (no pending, no ovf); counter decrements to 0 each cycle.
REQ-028 Macro BTN_ARB_HOLDOFF_EN undefined: no holdoff counters exist; HOLDOFF parameter is unused; every qualifying edge obeys REQ-014.

Verification
REQ-029 Reset, ev_in[0] 0->1 held high, cmd_ready=0 -> cmd_valid=1, cmd_id=0 two cycles after edge; exactly one entry, fifo_count=1, no further entries.
REQ-030 Edges on ev_in[3:0] simultaneously, cmd_ready=1 -> cmd_id sequence 0,1,2,3 on consecutive cycles; second round with same edges starting last_grant=1 yields 2,3,0,1.
REQ-031 cmd_ready=0, six single-edge events on distinct/repeating requesters, FIFO_DEPTH=4 -> fifo_count saturates at 4, remaining events held pending; repeated edge on a pending requester sets ovf bit; ovf_clr pulse clears it.
REQ-032 FIFO full, cmd_ready=1 with pending request -> push and pop same cycle, fifo_count stays 4, ordering preserved.
REQ-033 rst_n asserted with 3 entries queued and ev_in[1] high -> cmd_valid 0 immediately; after release no event for requester 1 until it drops and rises again.
REQ-034 BTN_ARB_HOLDOFF_EN defined, HOLDOFF=10: two edges on ev_in[2] 5 cycles apart -> one command; edge 12 cycles after grant -> second command, ovf stays 0.
